// File: rtl/thresh_pkg.sv
// Shared definitions for the threshold-load scheduler.
// Holds the 3-bit FSM state encoding, the requester index constants
// and a small helper that steps a requester index round the ring.
package thresh_pkg;

    localparam int N_REQ = 3;

    typedef logic [1:0] req_idx_t;

    localparam req_idx_t REQ_SLOW_CTRL   = 2'd0;
    localparam req_idx_t REQ_SEU_REFRESH = 2'd1;
    localparam req_idx_t REQ_POWER_UP    = 2'd2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        WAIT_DONE = 3'd2,
        RELEASE   = 3'd3,
        ACK_ST    = 3'd4,
        ERR       = 3'd5
    } state_t;

    // Successor of a requester index, wrapping 2 -> 0.
    function automatic req_idx_t next_idx(input req_idx_t idx);
        return (idx == REQ_POWER_UP) ? REQ_SLOW_CTRL : req_idx_t'(idx + 2'd1);
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way rotating-priority selector.
// Ports:
//   req        - pending request bits, one per requester
//   last_grant - index served most recently; it gets lowest priority
//   valid      - at least one request is pending
//   grant      - index of the winning requester (meaningful when valid)
module rr_arb3
    import thresh_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  req_idx_t         last_grant,
    output logic             valid,
    output req_idx_t         grant
);

    req_idx_t first_idx;
    req_idx_t second_idx;

    // Search order starts just after the last winner, so a requester that
    // keeps its request up waits for at most two other loads.
    always_comb begin
        first_idx  = next_idx(last_grant);
        second_idx = next_idx(first_idx);
        valid      = 1'b1;
        grant      = last_grant;
        if (req[first_idx]) begin
            grant = first_idx;
        end else if (req[second_idx]) begin
            grant = second_idx;
        end else if (req[last_grant]) begin
            grant = last_grant;
        end else begin
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/comp_thresh_sched.sv
// Threshold-load scheduler: arbitrates three requesters (slow control,
// SEU refresh, power-up init) for the single threshold load FSM, hands it
// the granted 16-bit word, supervises completion with a timeout and
// returns a one-cycle ACK to the requester that was served.
// Ports:
//   CLK, RST  - clock and synchronous active-high reset
//   REQ[2:0]  - level requests, held until ACK
//   DIN[47:0] - threshold word per requester, slice i at [16i+15:16i]
//   SET_DONE  - completion level from the load FSM
//   CLR_ERR   - clears the sticky timeout flag
//   START     - load request to the load FSM
//   LD_DATA   - word latched at grant time, stable while BUSY
//   ACK[2:0]  - one-cycle completion pulse to the served requester
//   BUSY      - high whenever the scheduler is not idle
//   TMO_ERR   - sticky flag, set when a load timed out
module comp_thresh_sched
    import thresh_pkg::*;
#(
    parameter int TMO_CYC = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [2:0]  REQ,
    input  logic [47:0] DIN,
    input  logic        SET_DONE,
    input  logic        CLR_ERR,
    output logic        START,
    output logic [15:0] LD_DATA,
    output logic [2:0]  ACK,
    output logic        BUSY,
    output logic        TMO_ERR
);

    localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

    state_t     state;
    state_t     next_state;
    req_idx_t   grant_idx;
    req_idx_t   last_grant;
    logic [7:0] tmo_cnt;
    logic       just_acked;
    logic [2:0] req_eff;
    logic       arb_valid;
    req_idx_t   arb_grant;
    logic       timeout;

    logic       start_d;
    logic       busy_d;
    logic [2:0] ack_d;
    logic       tmo_err_d;

    // The requester acknowledged last cycle may still hold REQ while it
    // reacts to ACK, so it is hidden from the arbiter for that one cycle.
    always_comb begin
        req_eff = REQ;
        if (just_acked) begin
            req_eff = REQ & ~(3'b001 << last_grant);
        end
    end

    rr_arb3 u_arb (
        .req        (req_eff),
        .last_grant (last_grant),
        .valid      (arb_valid),
        .grant      (arb_grant)
    );

    assign timeout = (tmo_cnt == TMO_LAST);

    // State register plus all registered outputs and datapath latches.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            START      <= 1'b0;
            BUSY       <= 1'b0;
            ACK        <= 3'b000;
            TMO_ERR    <= 1'b0;
            LD_DATA    <= 16'h0000;
            tmo_cnt    <= 8'd0;
            grant_idx  <= REQ_SLOW_CTRL;
            last_grant <= REQ_POWER_UP;
            just_acked <= 1'b0;
        end else begin
            state      <= next_state;
            START      <= start_d;
            BUSY       <= busy_d;
            ACK        <= ack_d;
            TMO_ERR    <= tmo_err_d;
            just_acked <= (state == ACK_ST);
            if (state == IDLE && arb_valid) begin
                grant_idx <= arb_grant;
                LD_DATA   <= DIN[{arb_grant, 4'b0000} +: 16];
            end
            // LOAD always precedes WAIT_DONE, so clearing here zeroes the
            // counter on entry to the wait.
            if (state == LOAD) begin
                tmo_cnt <= 8'd0;
            end else if (state == WAIT_DONE) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
            if (state == ACK_ST) begin
                last_grant <= grant_idx;
            end
        end
    end

    // Next-state logic; completion beats a simultaneous timeout.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (arb_valid) next_state = LOAD;
            LOAD:      next_state = WAIT_DONE;
            WAIT_DONE: begin
                if (SET_DONE) begin
                    next_state = RELEASE;
                end else if (timeout) begin
                    next_state = ERR;
                end
            end
            RELEASE:   if (!SET_DONE) next_state = ACK_ST;
            ACK_ST:    next_state = IDLE;
            ERR:       next_state = RELEASE;
            default:   next_state = IDLE;
        endcase
    end

    // Output decode from the upcoming state so each registered output is
    // aligned with the state it belongs to. Setting TMO_ERR wins over a
    // clear in the same cycle.
    always_comb begin
        start_d   = (next_state == LOAD) || (next_state == WAIT_DONE);
        busy_d    = (next_state != IDLE);
        ack_d     = 3'b000;
        if (next_state == ACK_ST) begin
            ack_d = 3'b001 << grant_idx;
        end
        tmo_err_d = TMO_ERR;
        if (next_state == ERR) begin
            tmo_err_d = 1'b1;
        end else if (CLR_ERR) begin
            tmo_err_d = 1'b0;
        end
    end

endmodule

// File: doc/comp_thresh_sched.md
COMP_THRESH_SCHED -- requirements
Module: comp_thresh_sched

Interface
REQ-001 SHALL have parameter TMO_CYC, default 64, meaning the maximum number of WAIT_DONE cycles before a load is declared failed (legal range 20..255).
REQ-002 SHALL have ports: CLK  in  1  system clock; all logic on rising edge.
REQ-003 SHALL have ports: RST  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: REQ  in  3  per-requester load request (0=slow-control write, 1=SEU refresh, 2=power-up init), level, held until ACK.
REQ-005 SHALL have ports: DIN  in  48  three 16-bit threshold words, requester i at bits [16i+15:16i].
REQ-006 SHALL have ports: SET_DONE  in  1  done level from the threshold load FSM (negedge-registered, same clock).
REQ-007 SHALL have ports: CLR_ERR  in  1  clears TMO_ERR.
REQ-008 SHALL have ports: START  out  1  load request to the threshold load FSM.
REQ-009 SHALL have ports: LD_DATA  out  16  latched word for the granted requester, stable while BUSY.
REQ-010 SHALL have ports: ACK  out  3  one-cycle completion pulse to the granted requester.
REQ-011 SHALL have ports: BUSY  out  1  high in every state except IDLE.
REQ-012 SHALL have ports: TMO_ERR  out  1  sticky timeout flag.

Function
REQ-013 SHALL implement states IDLE, LOAD, WAIT_DONE, RELEASE, ACK_ST, ERR.
REQ-014 SHALL, in IDLE with any REQ high, grant round-robin starting at index (last_grant+1) mod 3, latch DIN slice into LD_DATA and grant index, and go to LOAD next cycle.
REQ-015 SHALL hold START=1 in LOAD and WAIT_DONE only; LOAD lasts exactly one cycle, then WAIT_DONE.
REQ-016 SHALL clear the timeout counter on entry to WAIT_DONE and increment it each WAIT_DONE cycle.
REQ-017 SHALL go WAIT_DONE -> RELEASE when SET_DONE=1; SET_DONE and timeout in the same cycle SHALL resolve to RELEASE.
REQ-018 SHALL go WAIT_DONE -> ERR when counter reaches TMO_CYC-1 with SET_DONE=0.
REQ-019 SHALL hold START=0 in RELEASE and go to ACK_ST when SET_DONE=0 (load FSM returned to Idle).
REQ-020 SHALL, in ACK_ST, pulse ACK[grant] for exactly one cycle, update last_grant=grant, and return to IDLE.
REQ-021 SHALL, in ERR, set TMO_ERR, keep START=0, and go to RELEASE (requester still receives ACK).
REQ-022 SHALL not re-grant a requester in the cycle after its ACK (requester has one cycle to drop REQ).
REQ-023 SHALL ignore REQ changes and DIN changes while BUSY=1.
REQ-024 SHALL clear TMO_ERR on CLR_ERR=1 unless set in the same cycle; set wins.
REQ-025 SHALL ensure at most one ACK bit is high in any cycle.
REQ-026 SHALL give the worst-case grant latency for a waiting requester as two full load cycles.

Reset
REQ-027 SHALL on RST=1 at a clock edge force IDLE, START=0, ACK=0, BUSY=0, TMO_ERR=0, LD_DATA=0, counter=0, last_grant=2 (first grant priority 0,1,2).
REQ-028 SHALL abandon an in-progress load on RST without issuing ACK; the load FSM is reset by the same RST.

Structure
REQ-029 SHALL place the state encoding (3-bit) and requester index constants in a shared package thresh_pkg.
REQ-030 SHALL implement the rotating priority selection as sub-module rr_arb3 (inputs REQ, last_grant; outputs valid, grant index).
REQ-031 SHALL register START, ACK, BUSY, LD_DATA and TMO_ERR directly (no combinational outputs).

Verification
REQ-032 SHALL cover: REQ=3'b001, DIN[15:0]=16'hA5C3, model FSM asserts SET_DONE 18 cycles after START -> START high 19 cycles, LD_DATA=16'hA5C3, ACK=3'b001 one cycle after SET_DONE falls.
REQ-033 SHALL cover: REQ=3'b111 held after each ACK drop/re-raise -> grant order 0,1,2,0.
REQ-034 SHALL cover: SET_DONE never asserted, TMO_CYC=64 -> START drops after 64 WAIT_DONE cycles, TMO_ERR=1, ACK pulse issued; CLR_ERR -> TMO_ERR=0.
REQ-035 SHALL cover: RST pulsed mid-WAIT_DONE -> next cycle START=0, BUSY=0, no ACK, next grant goes to requester 0.
REQ-036 SHALL cover: SET_DONE rises on the timeout cycle -> RELEASE, TMO_ERR stays 0.
REQ-037 SHALL cover: DIN changed to 16'h0000 during WAIT_DONE -> LD_DATA unchanged until next grant.
